mips_cpu_muldiv: RTL and testbench



---
 rtl/mips_cpu_muldiv.sv | 155 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-fixed in one extra cycle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               in_signed;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     add_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  // prod_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    in_signed = ~op[0];
    mag_a_in  = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b_in  = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {add_sum, prod_q[WIDTH-1:1]};

    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (div_shift >= {1'b0, mag_b_q}) begin
      div_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end

    prod_neg = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end else if (b_zero_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = sign_a_q ? -rem : rem;
      fix_lo = (sign_a_q ^ sign_b_q) ? -quo : quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    a_d      = a_q;
    mag_b_d  = mag_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod_d   = prod_q;

    if (clk_enable) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RUN;
            count_d  = '0;
            is_div_d = op[1];
            sign_a_d = in_signed & operand_a[WIDTH-1];
            sign_b_d = in_signed & operand_b[WIDTH-1];
            b_zero_d = (operand_b == '0);
            a_d      = operand_a;
            mag_b_d  = mag_b_in;
            prod_d   = {{WIDTH{1'b0}}, mag_a_in};
          end else begin
            state_d = IDLE;
            if (mthi) hi_d = operand_a;
            if (mtlo) lo_d = operand_a;
          end
        end
        RUN: begin
          prod_d  = is_div_q ? div_next : mul_next;
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = FIX;
        end
        FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      a_q      <= a_d;
      mag_b_q  <= mag_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      prod_q   <= prod_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: a WIDTH=32 instance for the main scenarios and a WIDTH=8 instance.
// Expected {hi,lo} pairs are queued as each op starts and popped when done rises.
module tb_mips_cpu_muldiv;
  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8, mthi8, mtlo8;
  logic [1:0]  op8;
  logic [7:0]  operand_a8, operand_b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];
  logic        done_prev = 1'b0;
  logic        done8_prev = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_cpu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start8), .op(op8),
    .operand_a(operand_a8), .operand_b(operand_b8), .mthi(mthi8), .mtlo(mtlo8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Scoreboard side: compare results on the rising edge of done.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: hi=%h lo=%h with nothing queued", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e)
          begin
            errors++;
            $display("[TB] FAIL result32: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
          end
      end
    end
    if (done8 === 1'b1 && done8_prev !== 1'b1) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done8: hi=%h lo=%h with nothing queued", hi8, lo8);
      end else begin
        logic [15:0] e8;
        e8 = exp8_q.pop_front();
        if ({hi8, lo8} !== e8)
          begin
            errors++;
            $display("[TB] FAIL result8: got hi=%h lo=%h expected hi=%h lo=%h", hi8, lo8, e8[15:8], e8[7:0]);
          end
      end
    end
    done_prev  <= done;
    done8_prev <= done8;
  end

  // Reference model used for the random operations.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'd0: return 64'(longint'(sa) * longint'(sb));
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; the next posedge is edge 0 of the operation.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] expected);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    exp_q.push_back(expected);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expected);
    start8 = 1'b1;
    op8 = o;
    operand_a8 = a;
    operand_b8 = b;
    exp8_q.push_back(expected);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run_busy(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_busy8(output int cyc);
    cyc = 0;
    while (busy8 === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    checks++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      errors++; $display("[TB] FAIL reset_dut8: got busy=%b done=%b hi=%h lo=%h expected zeros", busy8, done8, hi8, lo8);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    int cyc;
    apply_stimulus(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 33", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mult_done_high: got %b expected 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_multu();
    int cyc;
    apply_stimulus(2'd1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
    run_busy(cyc);
    apply_stimulus(2'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", cyc); end
  endtask

  task automatic test_div();
    int cyc;
    apply_stimulus(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_busy(cyc);
    apply_stimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d expected 33", cyc); end
  endtask

  task automatic test_div_zero();
    int cyc;
    apply_stimulus(2'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divu0_busy_cycles: got %0d expected 33", cyc); end
    apply_stimulus(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL div0_busy_cycles: got %0d expected 33", cyc); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    mthi = 1'b1; operand_a = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("[TB] FAIL mthi_idle: got %h expected 00001234", hi); end
    mtlo = 1'b1; operand_a = 32'h0000_5A5A;
    @(negedge clk);
    mtlo = 1'b0;
    checks++; if (lo !== 32'h0000_5A5A) begin errors++; $display("[TB] FAIL mtlo_idle: got %h expected 00005a5a", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("[TB] FAIL mtlo_keeps_hi: got %h expected 00001234", hi); end
  endtask

  task automatic test_mtlo_run();
    int cyc;
    apply_stimulus(2'd1, 32'd2, 32'd3, {32'd0, 32'd6});
    repeat (3) @(negedge clk);
    mtlo = 1'b1; mthi = 1'b1; operand_a = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b0;
    checks++; if (lo !== 32'h0000_5A5A) begin errors++; $display("[TB] FAIL mtlo_in_run: got %h expected 00005a5a", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("[TB] FAIL mthi_in_run: got %h expected 00001234", hi); end
    run_busy(cyc);
  endtask

  task automatic test_start_mthi();
    int cyc;
    mthi = 1'b1; operand_a = 32'hAAAA_AAAA;
    @(negedge clk);
    mthi = 1'b1;
    apply_stimulus(2'd1, 32'h55, 32'd3, {32'd0, 32'hFF});
    mthi = 1'b0;
    checks++; if (hi !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL start_beats_mthi: got %h expected aaaaaaaa", hi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_with_mthi_busy: got %b expected 1", busy); end
    run_busy(cyc);
  endtask

  task automatic test_clk_enable();
    int cyc;
    apply_stimulus(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    repeat (10) @(negedge clk);
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    clk_enable = 1'b1;
    run_busy(cyc);
    checks++; if (cyc + 15 !== 38) begin errors++; $display("[TB] FAIL clk_enable_stretch: got %0d cycles expected 38", cyc + 15); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    apply_stimulus(2'd1, 32'd1000, 32'd1000, {32'd0, 32'd1000000});
    run_busy(cyc);
    apply_stimulus(2'd3, 32'd1000, 32'd33, {32'd10, 32'd30});
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    run_busy(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected 33", cyc); end
  endtask

  task automatic test_random();
    int cyc;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) b = b >> 20;
      if (b == 32'd0) b = 32'd1;
      apply_stimulus(o, a, b, model(o, a, b));
      run_busy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL random_busy_cycles: op=%0d got %0d expected 33", o, cyc); end
    end
  endtask

  task automatic test_width8();
    int cyc;
    apply_stimulus8(2'd3, 8'd200, 8'd7, {8'd4, 8'd28});
    run_busy8(cyc);
    checks++; if (cyc !== 9) begin errors++; $display("[TB] FAIL w8_divu_busy_cycles: got %0d expected 9", cyc); end
    apply_stimulus8(2'd0, 8'h80, 8'h80, {8'h40, 8'h00});
    run_busy8(cyc);
    checks++; if (cyc !== 9) begin errors++; $display("[TB] FAIL w8_mult_busy_cycles: got %0d expected 9", cyc); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] dropped;
    apply_stimulus(2'd0, 32'h0001_2345, 32'h0000_0777, model(2'd0, 32'h0001_2345, 32'h0000_0777));
    dropped = exp_q.pop_back();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("[TB] FAIL abort_hilo: got hi=%h lo=%h expected 0", hi, lo); end
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy=%b done=%b expected 0 0 (dropped %h)", busy, done, dropped); end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    start8 = 1'b0; mthi8 = 1'b0; mtlo8 = 1'b0; op8 = 2'd0; operand_a8 = '0; operand_b8 = '0;
    repeat (2) @(negedge clk);
    $display("[TB] starting mips_cpu_muldiv bench");
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_mtlo_run();
    test_start_mthi();
    test_clk_enable();
    test_back_to_back();
    test_random();
    test_width8();
    @(negedge clk);
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d results outstanding expected 0/0", exp_q.size(), exp8_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
